// File: rtl/ame_num_normal_pipe_if.sv
// Valid/ready bus for the AME multi-lane normaliser: input transaction and result.
interface ame_num_normal_pipe_if #(
  parameter int DATA_BITS = 64,
  parameter int OUT_BITS  = 32,
  parameter int LANES     = 4,
  parameter int ID_BITS   = 4
);
  localparam int SH_BITS = $clog2(DATA_BITS);

  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [ID_BITS-1:0]         in_id_i;
  logic [1:0]                 in_mode_i;
  logic [SH_BITS-1:0]         in_shift_i;
  logic [LANES*DATA_BITS-1:0] in_data_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [ID_BITS-1:0]         out_id_o;
  logic [LANES*OUT_BITS-1:0]  out_data_o;
  logic [LANES-1:0]           out_sat_o;

  // the normaliser side
  modport slave (
    input  in_valid_i, in_id_i, in_mode_i, in_shift_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_id_o, out_data_o, out_sat_o
  );

  // the producer/consumer side
  modport master (
    output in_valid_i, in_id_i, in_mode_i, in_shift_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_id_o, out_data_o, out_sat_o
  );
endinterface

// File: rtl/ame_num_normal_pipe.sv
// Multi-lane 2-stage signed right-shift normaliser with selectable rounding
// and saturation to OUT_BITS. Lanes share shift/mode; valid and tag ride a
// small shift register alongside the per-lane datapath.

// One lane: S1 = sign, shifted magnitude, round bit; S2 = increment, sign, clamp.
module ame_num_normal_lane #(
  parameter int DATA_BITS = 64,
  parameter int OUT_BITS  = 32,
  parameter int SH_BITS   = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DATA_BITS-1:0] x_i,
  input  logic [SH_BITS-1:0]   shift_i,
  input  logic [1:0]           mode_i,
  output logic [OUT_BITS-1:0]  res_o,
  output logic                 sat_o
);
  // one extra bit so |-2^(DATA_BITS-1)| and the round carry never wrap
  localparam int MW = DATA_BITS + 1;
  localparam int RW = MW + 1;

  logic          sign_d, sign_q;
  logic [MW-1:0] sh_d, sh_q;
  logic          rnd_d, rnd_q;
  logic [OUT_BITS-1:0] res_d, res_q;
  logic          sat_d, sat_q;

  logic [MW-1:0] mag, mask, mag_inc;
  logic [RW-1:0] r;
  logic          rnd_new, sat_hi, sat_lo;

  // S1: magnitude, truncated shift, and the +1 that turns truncation into the chosen mode
  always_comb begin
    mag     = x_i[DATA_BITS-1] ? (~{x_i[DATA_BITS-1], x_i} + {{(MW-1){1'b0}}, 1'b1})
                               : {1'b0, x_i};
    // low s bits of the magnitude: the part discarded by the shift
    mask    = ~({MW{1'b1}} << shift_i);
    rnd_new = 1'b0;
    case (mode_i)
      // half-away: increment when the top discarded bit (weight 2^(s-1)) is set
      2'b01:   rnd_new = |(mag & (mask ^ (mask >> 1)));
      // floor: negatives move one further from zero if anything was discarded
      2'b10:   rnd_new = x_i[DATA_BITS-1] & (|(mag & mask));
      default: rnd_new = 1'b0;
    endcase
    sign_d = sign_q;
    sh_d   = sh_q;
    rnd_d  = rnd_q;
    if (en_i) begin
      sign_d = x_i[DATA_BITS-1];
      sh_d   = mag >> shift_i;
      rnd_d  = rnd_new;
    end
  end

  // S2: apply increment, restore sign, clamp into OUT_BITS
  always_comb begin
    mag_inc = sh_q + {{(MW-1){1'b0}}, rnd_q};
    r       = sign_q ? -{1'b0, mag_inc} : {1'b0, mag_inc};
    // in range iff bits [RW-1:OUT_BITS-1] are all copies of the sign
    sat_hi  = ~r[RW-1] & (|r[RW-2:OUT_BITS-1]);
    sat_lo  =  r[RW-1] & ~(&r[RW-2:OUT_BITS-1]);
    res_d   = res_q;
    sat_d   = sat_q;
    if (en_i) begin
      sat_d = sat_hi | sat_lo;
      if (sat_hi)      res_d = {1'b0, {(OUT_BITS-1){1'b1}}};
      else if (sat_lo) res_d = {1'b1, {(OUT_BITS-1){1'b0}}};
      else             res_d = r[OUT_BITS-1:0];
    end
  end

  // lane pipeline registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sign_q <= 1'b0;
      sh_q   <= '0;
      rnd_q  <= 1'b0;
      res_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      sh_q   <= sh_d;
      rnd_q  <= rnd_d;
      res_q  <= res_d;
      sat_q  <= sat_d;
    end
  end

  assign res_o = res_q;
  assign sat_o = sat_q;
endmodule

// Top: shared stall control, valid/tag pipe, array of lanes.
module ame_num_normal_pipe #(
  parameter int DATA_BITS = 64,
  parameter int OUT_BITS  = 32,
  parameter int LANES     = 4,
  parameter int ID_BITS   = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  ame_num_normal_pipe_if.slave io
);
  localparam int SH_BITS = $clog2(DATA_BITS);
  localparam int STAGES  = 2;

  logic                             en;
  logic [STAGES:1]                  vld_pipe_d, vld_pipe_q;
  logic [ID_BITS-1:0]               id1_d, id1_q, id2_d, id2_q;
  logic [LANES-1:0][DATA_BITS-1:0]  lane_x;
  logic [LANES-1:0][OUT_BITS-1:0]   lane_res;
  logic [LANES-1:0]                 lane_sat;

  // whole pipe advances unless a result is held waiting for the consumer
  assign en         = ~io.out_valid_o | io.out_ready_i;
  assign io.in_ready_o = en;
  assign lane_x     = io.in_data_i;

  // valid shift register and tag pipe; bubbles load as valid=0
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    id1_d      = id1_q;
    id2_d      = id2_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[1], io.in_valid_i};
      id1_d      = io.in_id_i;
      id2_d      = id1_q;
    end
  end

  // control registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe_q <= '0;
      id1_q      <= '0;
      id2_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      id1_q      <= id1_d;
      id2_q      <= id2_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ame_num_normal_lane #(
      .DATA_BITS (DATA_BITS),
      .OUT_BITS  (OUT_BITS),
      .SH_BITS   (SH_BITS)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (en),
      .x_i     (lane_x[k]),
      .shift_i (io.in_shift_i),
      .mode_i  (io.in_mode_i),
      .res_o   (lane_res[k]),
      .sat_o   (lane_sat[k])
    );
  end

  assign io.out_valid_o = vld_pipe_q[STAGES];
  assign io.out_id_o    = id2_q;
  assign io.out_data_o  = lane_res;
  assign io.out_sat_o   = lane_sat;
endmodule
